dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port (dmem address/write-data/enable) between the ARM core and a second bus master, the sprite/mouse DMA engine, so that the DMA engine can move data without a second memory port. Sits between the core's memory interface and the address decoder/data memory in the top level. Grants at most one master per cycle, stalls the core when the DMA engine wins, and guarantees the DMA engine bounded waiting through a starvation counter.

## Interface
- DMA_WAIT, 4: consecutive denied DMA cycles after which the DMA engine is forced ahead of the core for one cycle (legal 1..15).
- AW, 32: address width.
- DW, 32: data width.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  core requests a memory access this cycle (load or store)
- cpu_we  in  1  core access is a write (MemWrite)
- cpu_addr  in  AW  core address (DataAdr)
- cpu_wdata  in  DW  core write data (WriteData)
- cpu_rdata  out  DW  read data to core, combinational pass-through of mem_rdata
- cpu_stall  out  1  core access not granted this cycle; core must hold PC and request
- dma_req  in  1  DMA engine requests an access; held until dma_gnt
- dma_we  in  1  DMA access is a write
- dma_addr  in  AW  DMA address
- dma_wdata  in  DW  DMA write data
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  DW  registered read data for the last granted DMA read
- dma_valid  out  1  one-cycle pulse: dma_rdata holds a fresh read result
- mem_en  out  1  memory access enable to address decoder
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  combinational read data from the decoder's read mux

## Operation
- State: owner register {IDLE, CPU, DMA} (last cycle's grantee), starvation counter starve_cnt (4 bits), dma_rdata/dma_valid registers.
- Grant decision (combinational, each cycle, reset low):
  - neither request: no grant; mem_en=0, mem_we=0, mem_addr/mem_wdata = 0.
  - only cpu_req: core granted.
  - only dma_req: DMA granted.
  - both: DMA granted if starve_cnt == DMA_WAIT, else core granted.
- Core granted: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_stall=0, dma_gnt=0.
- DMA granted: mem_en=1, mem_we=dma_we, mem_addr=dma_addr, mem_wdata=dma_wdata, dma_gnt=1, cpu_stall=cpu_req.
- cpu_stall = cpu_req & ~core granted; never asserted without cpu_req.
- starve_cnt: cleared when DMA granted or dma_req low; incremented when dma_req high and not granted; saturates at DMA_WAIT.
- owner register: loads grantee (IDLE if none) each cycle; drives no datapath, exported only for debug/verification of grant history.
- DMA read: on a DMA-granted cycle with dma_we=0, dma_rdata <= mem_rdata and dma_valid <= 1 at the next edge; otherwise dma_valid <= 0, dma_rdata holds.
- DMA write: no dma_valid pulse.

## Timing
- Core path fully combinational: zero added latency when granted, matching single-cycle core.
- DMA read latency: data on dma_rdata, dma_valid high, in the cycle after dma_gnt.
- Worst-case DMA wait under continuous core traffic: DMA_WAIT cycles, granted in cycle DMA_WAIT+1.
- Core maximum stall per forced DMA grant: 1 cycle; with back-to-back DMA requests core then wins the next DMA_WAIT cycles.
- Reset (while high, any cycle including mid-transfer): no grants, mem_en=0, mem_we=0, cpu_stall=0, dma_gnt=0; at edge: owner=IDLE, starve_cnt=0, dma_rdata=0, dma_valid=0. Pending DMA read result is discarded.
- Simultaneous request at starve_cnt==DMA_WAIT and reset: reset wins.

## Test plan
- Reset then idle: reset high 2 cycles -> mem_en=0, dma_valid=0, dma_rdata=0, cpu_stall=0, owner=IDLE.
- Core only: cpu_req=1, cpu_we=1, cpu_addr=0x40, cpu_wdata=0xDEADBEEF -> same cycle mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, cpu_stall=0.
- DMA read alone: dma_req=1, dma_we=0, dma_addr=0x80, mem_rdata=0x12345678 -> dma_gnt=1 that cycle; next cycle dma_valid=1, dma_rdata=0x12345678; following cycle dma_valid=0.
- Contention, DMA_WAIT=4: cpu_req and dma_req held high -> core granted cycles 1-4, starve_cnt 1..4; cycle 5 dma_gnt=1, cpu_stall=1; cycle 6 core granted, starve_cnt=1.
- Reset mid-operation: DMA read granted, reset asserted next edge -> dma_valid stays 0, dma_rdata=0, starve_cnt=0.
- DMA write with core idle: dma_req=1, dma_we=1, dma_addr=0x100, dma_wdata=0xA5 -> mem_we=1, mem_addr=0x100, mem_wdata=0xA5, no dma_valid pulse.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle: core request, DMA request and shared memory port.
// Pure wiring; no storage.
// Flow control is grant/stall based; there is no ready/valid buffering here.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Core side
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  // DMA side
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_valid;
  // Shared memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rdata, dma_valid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester/memory view (core, DMA engine and memory model together)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rdata, dma_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and the DMA engine.
// Latency: core path combinational; DMA read data registered, valid the cycle after grant.
// Backpressure: losing core sees cpu_stall; DMA holds dma_req until dma_gnt, forced ahead after DMA_WAIT denials.
module dmem_arbiter #(
  parameter int DMA_WAIT = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic       clk,
  input  logic       reset,
  dmem_arbiter_if.slave bus,
  output logic [1:0] o_owner,
  output logic [3:0] o_starve_cnt
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [3:0] LP_WAIT = 4'(DMA_WAIT);

  owner_t        r_owner;
  logic [3:0]    r_starve_cnt;
  logic [DW-1:0] r_dma_rdata;
  logic          r_dma_valid;

  logic          w_dma_gnt;
  logic          w_cpu_gnt;
  logic          w_starved;

  // Grant decision: DMA wins alone or once it has been denied DMA_WAIT times; reset blocks all grants.
  always_comb begin
    w_starved = (r_starve_cnt == LP_WAIT);
    w_dma_gnt = ~reset & bus.dma_req & (~bus.cpu_req | w_starved);
    w_cpu_gnt = ~reset & bus.cpu_req & ~w_dma_gnt;
  end

  // Memory port mux; drives zeros when idle so the decoder sees a quiet bus.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_dma_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end else if (w_cpu_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // Requester-facing status; core read data is a straight pass-through.
  always_comb begin
    bus.cpu_rdata = bus.mem_rdata;
    bus.cpu_stall = ~reset & bus.cpu_req & ~w_cpu_gnt;
    bus.dma_gnt   = w_dma_gnt;
    bus.dma_rdata = r_dma_rdata;
    bus.dma_valid = r_dma_valid;
    o_owner       = r_owner;
    o_starve_cnt  = r_starve_cnt;
  end

  // Grant history, starvation counter and DMA read capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_IDLE;
      r_starve_cnt <= '0;
      r_dma_rdata  <= '0;
      r_dma_valid  <= 1'b0;
    end else begin
      if (w_dma_gnt)      r_owner <= OWN_DMA;
      else if (w_cpu_gnt) r_owner <= OWN_CPU;
      else                r_owner <= OWN_IDLE;

      // Counts denied DMA cycles; saturates at the forcing threshold.
      if (!bus.dma_req || w_dma_gnt)
        r_starve_cnt <= '0;
      else if (!w_starved)
        r_starve_cnt <= r_starve_cnt + 4'd1;

      // Capture read data only for granted DMA reads; writes produce no pulse.
      if (w_dma_gnt && !bus.dma_we) begin
        r_dma_rdata <= bus.mem_rdata;
        r_dma_valid <= 1'b1;
      end else begin
        r_dma_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] owner;
  logic [3:0] starve;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.DMA_WAIT(4), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_owner      (owner),
    .o_starve_cnt (starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [31:0] mrd;
    // expected, same cycle
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        stall;
    logic        gnt;
    // expected, after the edge
    logic        valid;
    logic [31:0] rdata;
    logic [1:0]  own;
    logic [3:0]  stc;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    bus.cpu_req   = v.creq;
    bus.cpu_we    = v.cwe;
    bus.cpu_addr  = v.caddr;
    bus.cpu_wdata = v.cwd;
    bus.dma_req   = v.dreq;
    bus.dma_we    = v.dwe;
    bus.dma_addr  = v.daddr;
    bus.dma_wdata = v.dwd;
    bus.mem_rdata = v.mrd;
  endtask

  // Drive, check combinational outputs mid-cycle, clock, check registered state.
  task automatic apply(input string tag, input vec_t v);
    drive(v);
    #2;
    chk({tag, " mem_en"},    32'(bus.mem_en),    32'(v.en));
    chk({tag, " mem_we"},    32'(bus.mem_we),    32'(v.we));
    chk({tag, " mem_addr"},  bus.mem_addr,       v.addr);
    chk({tag, " mem_wdata"}, bus.mem_wdata,      v.wd);
    chk({tag, " cpu_stall"}, 32'(bus.cpu_stall), 32'(v.stall));
    chk({tag, " dma_gnt"},   32'(bus.dma_gnt),   32'(v.gnt));
    chk({tag, " cpu_rdata"}, bus.cpu_rdata,      v.mrd);
    @(posedge clk);
    #1;
    chk({tag, " dma_valid"}, 32'(bus.dma_valid), 32'(v.valid));
    chk({tag, " dma_rdata"}, bus.dma_rdata,      v.rdata);
    chk({tag, " owner"},     32'(owner),         32'(v.own));
    chk({tag, " starve"},    32'(starve),        32'(v.stc));
  endtask

  function automatic vec_t mk(
    logic rst, logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
    logic dreq, logic dwe, logic [31:0] daddr, logic [31:0] dwd, logic [31:0] mrd,
    logic en, logic we, logic [31:0] addr, logic [31:0] wd, logic stall, logic gnt,
    logic valid, logic [31:0] rdata, logic [1:0] own, logic [3:0] stc);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
    v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.stall = stall; v.gnt = gnt;
    v.valid = valid; v.rdata = rdata; v.own = own; v.stc = stc;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   cyc;
    bit   got;

    //            rst creq cwe caddr   cwd           dreq dwe daddr   dwd     mrd
    //            en we addr    wd            stall gnt valid rdata         own stc
    // reset, idle
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,  32'h0,
                      0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        2'd0, 4'd0));
    // reset with both requesting: nothing granted
    vecs.push_back(mk(1, 1, 1, 32'h44,  32'h1,        1, 0, 32'h88,  32'h2,  32'h9,
                      0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        2'd0, 4'd0));
    // core write alone
    vecs.push_back(mk(0, 1, 1, 32'h40,  32'hDEADBEEF, 0, 0, 32'h0,   32'h0,  32'h0,
                      1, 1, 32'h40,  32'hDEADBEEF, 0, 0, 0, 32'h0,        2'd1, 4'd0));
    // DMA read alone
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,        1, 0, 32'h80,  32'h0,  32'h12345678,
                      1, 0, 32'h80,  32'h0,        0, 1, 1, 32'h12345678, 2'd2, 4'd0));
    // idle: valid drops, rdata holds
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,  32'hFFFF,
                      0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h12345678, 2'd0, 4'd0));
    // DMA write alone: no valid pulse
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,        1, 1, 32'h100, 32'hA5, 32'h77,
                      1, 1, 32'h100, 32'hA5,       0, 1, 0, 32'h12345678, 2'd2, 4'd0));
    // contention: core wins four times while starve climbs
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0, 1, 0, 32'h200, 32'h11,     1, 0, 32'h300, 32'h22, 32'h5000 + 32'(i),
                        1, 0, 32'h200, 32'h11,     0, 0, 0, 32'h12345678, 2'd1, 4'(i)));
    // fifth cycle: DMA forced, core stalled
    vecs.push_back(mk(0, 1, 0, 32'h200, 32'h11,       1, 0, 32'h300, 32'h22, 32'hCAFEF00D,
                      1, 0, 32'h300, 32'h22,       1, 1, 1, 32'hCAFEF00D, 2'd1 + 2'd1, 4'd0));
    // sixth cycle: core again, starve restarts
    vecs.push_back(mk(0, 1, 0, 32'h200, 32'h11,       1, 0, 32'h300, 32'h22, 32'h0BAD,
                      1, 0, 32'h200, 32'h11,       0, 0, 0, 32'hCAFEF00D, 2'd1, 4'd1));
    // DMA drops its request: counter clears
    vecs.push_back(mk(0, 1, 1, 32'h204, 32'h33,       0, 0, 32'h300, 32'h22, 32'h0,
                      1, 1, 32'h204, 32'h33,       0, 0, 0, 32'hCAFEF00D, 2'd1, 4'd0));

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-operation: build starvation, then a DMA read meets reset at the edge.
    v = mk(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 32'h0,
           1, 0, 32'h10, 32'h0, 0, 0, 0, 32'hCAFEF00D, 2'd1, 4'd1);
    apply("rst_seq c1", v);
    v.stc = 4'd2;
    apply("rst_seq c2", v);
    v = mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h80, 32'h0, 32'h600D,
           1, 0, 32'h80, 32'h0, 0, 1, 1, 32'h600D, 2'd2, 4'd0);
    apply("rst_seq dma", v);
    v = mk(1, 1, 0, 32'h10, 32'h0, 1, 0, 32'h80, 32'h0, 32'hBEEF,
           0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'd0, 4'd0);
    apply("rst_seq reset", v);

    // Bounded wait: DMA must win on cycle DMA_WAIT+1 under continuous core traffic.
    v = mk(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 32'h0,
           0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'd0, 4'd0);
    drive(v);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      cyc++;
      #2;
      if (bus.dma_gnt) begin
        got = 1'b1;
        chk("wait stall_on_forced", 32'(bus.cpu_stall), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    chk("wait grant_cycle", 32'(cyc), 32'd5);
    #2;
    chk("wait core_next", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("wait starve_restart", 32'(starve), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
